// File: rtl/tim_event_gen.sv
// tim_event_gen: one-cycle event pulses, sticky status/overcapture flags, interrupt enables and irq for a timer
module tim_event_gen #(
    parameter int N_EVT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             egr_we,
    input  logic [N_EVT-1:0] egr_wdata,
    input  logic             sr_we,
    input  logic [N_EVT-1:0] sr_wdata,
    input  logic [N_EVT-1:0] ovr_wdata,
    input  logic             dier_we,
    input  logic [N_EVT-1:0] dier_wdata,
    input  logic             urs,
    input  logic [N_EVT-1:0] hw_evt,
    output logic [N_EVT-1:0] evt_pulse,
    output logic [N_EVT-1:0] egr_rdata,
    output logic [N_EVT-1:0] sr_flags,
    output logic [N_EVT-1:0] ovr_flags,
    output logic [N_EVT-1:0] dier,
    output logic             irq
);
    logic [N_EVT-1:0] evt_pulse_q, evt_pulse_d;
    logic [N_EVT-1:0] sr_q, sr_d;
    logic [N_EVT-1:0] ovr_q, ovr_d;
    logic [N_EVT-1:0] dier_q, dier_d;
    logic [N_EVT-1:0] sw_mask, ch_mask, sr_clr, ovr_clr, ovr_set;
    always_comb begin
        sw_mask = '1;
        sw_mask[0] = ~urs;
        ch_mask = '1;
        ch_mask[0] = 1'b0;
        evt_pulse_d = egr_we ? egr_wdata : '0;
        sr_clr = sr_we ? ~sr_wdata : '0;
        ovr_clr = sr_we ? ~ovr_wdata : '0;
        // overcapture judged on the pre-edge flag; a same-cycle clear suppresses it
        ovr_set = hw_evt & sr_q & ~sr_clr & ch_mask;
        sr_d = (sr_q & ~sr_clr) | (evt_pulse_d & sw_mask) | hw_evt;
        ovr_d = ((ovr_q & ~ovr_clr) | ovr_set) & ch_mask;
        dier_d = dier_we ? dier_wdata : dier_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_pulse_q <= '0;
            sr_q <= '0;
            ovr_q <= '0;
            dier_q <= '0;
        end else begin
            evt_pulse_q <= evt_pulse_d;
            sr_q <= sr_d;
            ovr_q <= ovr_d;
            dier_q <= dier_d;
        end
    end
    assign evt_pulse = evt_pulse_q;
    assign egr_rdata = '0;
    assign sr_flags = sr_q;
    assign ovr_flags = ovr_q;
    assign dier = dier_q;
    assign irq = |(sr_q & dier_q);
endmodule

// File: tb/tb_tim_event_gen.sv
// tb_tim_event_gen: directed self-checking bench for tim_event_gen
module tb_tim_event_gen;
    logic clk = 1'b0;
    logic rst, egr_we, sr_we, dier_we, urs, irq;
    logic [3:0] egr_wdata, sr_wdata, ovr_wdata, dier_wdata, hw_evt;
    logic [3:0] evt_pulse, egr_rdata, sr_flags, ovr_flags, dier;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    tim_event_gen #(.N_EVT(4)) dut (
        .clk(clk), .rst(rst), .egr_we(egr_we), .egr_wdata(egr_wdata),
        .sr_we(sr_we), .sr_wdata(sr_wdata), .ovr_wdata(ovr_wdata),
        .dier_we(dier_we), .dier_wdata(dier_wdata), .urs(urs), .hw_evt(hw_evt),
        .evt_pulse(evt_pulse), .egr_rdata(egr_rdata), .sr_flags(sr_flags),
        .ovr_flags(ovr_flags), .dier(dier), .irq(irq)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1; egr_we = 0; sr_we = 0; dier_we = 0; urs = 0;
        egr_wdata = 0; sr_wdata = 4'hf; ovr_wdata = 4'hf; dier_wdata = 0; hw_evt = 0;
        step(); step();
        chk("rst_evt", 32'(evt_pulse), 0);
        chk("rst_sr", 32'(sr_flags), 0);
        chk("rst_ovr", 32'(ovr_flags), 0);
        chk("rst_dier", 32'(dier), 0);
        chk("rst_irq", 32'(irq), 0);
        rst = 0;
        step();
        egr_we = 1; egr_wdata = 4'b0001;
        step();
        egr_we = 0;
        chk("ug_pulse", 32'(evt_pulse), 4'b0001);
        chk("ug_uif", 32'(sr_flags), 4'b0001);
        chk("ug_rdata", 32'(egr_rdata), 0);
        step();
        chk("ug_once", 32'(evt_pulse), 0);
        chk("ug_sticky", 32'(sr_flags), 4'b0001);
        sr_we = 1; sr_wdata = 0;
        step();
        sr_we = 0; sr_wdata = 4'hf;
        chk("uif_clr", 32'(sr_flags), 0);
        urs = 1; egr_we = 1; egr_wdata = 4'b0001;
        step();
        egr_we = 0;
        chk("urs_pulse", 32'(evt_pulse), 4'b0001);
        chk("urs_nouif", 32'(sr_flags), 0);
        hw_evt = 4'b0001;
        step();
        hw_evt = 0;
        chk("hw_uif_urs", 32'(sr_flags), 4'b0001);
        urs = 0; sr_we = 1; sr_wdata = 0;
        step();
        sr_we = 0; sr_wdata = 4'hf;
        dier_we = 1; dier_wdata = 4'b0100;
        step();
        dier_we = 0;
        chk("dier_load", 32'(dier), 4'b0100);
        chk("irq_idle", 32'(irq), 0);
        hw_evt = 4'b1110;
        step();
        hw_evt = 0;
        chk("hw_set", 32'(sr_flags), 4'b1110);
        chk("irq_rise", 32'(irq), 1);
        sr_we = 1; sr_wdata = 4'b1011;
        step();
        sr_we = 0; sr_wdata = 4'hf;
        chk("clr_bit2", 32'(sr_flags), 4'b1010);
        chk("irq_fall", 32'(irq), 0);
        chk("dier_hold", 32'(dier), 4'b0100);
        sr_we = 1; sr_wdata = 0;
        step();
        sr_we = 0; sr_wdata = 4'hf;
        chk("clr_all", 32'(sr_flags), 0);
        hw_evt = 4'b0010;
        step();
        hw_evt = 0;
        chk("ovr_first", 32'(ovr_flags), 0);
        step(); step();
        hw_evt = 4'b0010;
        step();
        hw_evt = 0;
        chk("ovr_second", 32'(ovr_flags), 4'b0010);
        chk("ovr_sr", 32'(sr_flags), 4'b0010);
        sr_we = 1; ovr_wdata = 4'b1101;
        step();
        sr_we = 0; ovr_wdata = 4'hf;
        chk("ovr_clr", 32'(ovr_flags), 0);
        chk("ovr_clr_sr", 32'(sr_flags), 4'b0010);
        hw_evt = 4'b1000;
        step();
        chk("set3", 32'(sr_flags), 4'b1010);
        sr_we = 1; sr_wdata = 4'b0111;
        step();
        hw_evt = 0; sr_we = 0; sr_wdata = 4'hf;
        chk("setwin_sr", 32'(sr_flags), 4'b1010);
        chk("setwin_ovr", 32'(ovr_flags), 0);
        egr_we = 1; egr_wdata = 4'b0100; sr_we = 1; sr_wdata = 0;
        step();
        sr_we = 0; sr_wdata = 4'hf;
        chk("sw_setwin", 32'(sr_flags), 4'b0100);
        chk("hold_p1", 32'(evt_pulse), 4'b0100);
        step();
        egr_we = 0;
        chk("hold_p2", 32'(evt_pulse), 4'b0100);
        chk("irq_sw", 32'(irq), 1);
        step();
        chk("hold_end", 32'(evt_pulse), 0);
        egr_we = 1; egr_wdata = 4'b1111;
        step();
        chk("all_pulse", 32'(evt_pulse), 4'b1111);
        #2 rst = 1;
        #1;
        chk("arst_evt", 32'(evt_pulse), 0);
        chk("arst_sr", 32'(sr_flags), 0);
        chk("arst_ovr", 32'(ovr_flags), 0);
        chk("arst_dier", 32'(dier), 0);
        chk("arst_irq", 32'(irq), 0);
        egr_we = 0;
        step();
        rst = 0;
        step();
        chk("post_rst_evt", 32'(evt_pulse), 0);
        chk("post_rst_sr", 32'(sr_flags), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tim_event_gen.md
Name: tim_event_gen

Overview:
- Parametrised event-generation and status block for the timer family.
- Software writes N event bits; each set bit produces a one-cycle event pulse to the timer core. Bit 0 is UG (update/reinit); bits 1..N-1 are channel capture/compare generation.
- Also holds the sticky status flags (UIF, CCxIF), the overcapture flags, the interrupt-enable mask and a combined IRQ line.
- Synchronous to the peripheral clock. Replaces the older strobe-clocked single-bit UG latch.

Parameters:
- N_EVT, 4, number of event bits (bit 0 = update, 1..N_EVT-1 = channels); legal range 1..16.

Ports:
- clk  in  1  peripheral clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- egr_we  in  1  bus write strobe for the event-generation register
- egr_wdata  in  N_EVT  event request bits, 1 = generate
- sr_we  in  1  bus write strobe for the status register
- sr_wdata  in  N_EVT  flag write data (rc_w0: 0 clears, 1 no effect)
- ovr_wdata  in  N_EVT  overcapture write data, qualified by sr_we (rc_w0)
- dier_we  in  1  bus write strobe for the interrupt-enable register
- dier_wdata  in  N_EVT  interrupt-enable data
- urs  in  1  update request source; 1 = UG pulse does not set UIF
- hw_evt  in  N_EVT  single-cycle hardware events from the core (bit 0 = overflow/update, others = capture/compare)
- evt_pulse  out  N_EVT  one-cycle event pulses to the core (bit 0 = reinit counter/prescaler)
- egr_rdata  out  N_EVT  EGR readback, always 0
- sr_flags  out  N_EVT  sticky status flags
- ovr_flags  out  N_EVT  sticky overcapture flags; bit 0 tied 0
- dier  out  N_EVT  interrupt-enable register
- irq  out  1  interrupt request

Behaviour:
- Reset (async): evt_pulse, sr_flags, ovr_flags, dier = 0; irq = 0. Reset asserted mid-pulse kills the pulse immediately, and no pending event survives.
- EGR write at edge T: evt_pulse[i] = egr_wdata[i] during cycle T..T+1, exactly one cycle. The register self-clears and there is no storage beyond one cycle.
- egr_we held high on consecutive cycles with the same bit set gives one pulse per cycle (no edge detection).
- Software-set flag: at the same edge that raises evt_pulse[i], sr_flags[i] sets.
  - Exception for bit 0: UIF is not set when urs = 1 (sampled in the write cycle).
  - Bits i >= 1 always set their flag.
- Hardware set: hw_evt[i] = 1 at edge sets sr_flags[i]. urs does not gate hw_evt[0].
- Overcapture: for i >= 1, if hw_evt[i] = 1 while sr_flags[i] is already 1 and not being cleared in the same cycle, then ovr_flags[i] sets. Software events never set ovr.
- Clear: sr_we with sr_wdata[i] = 0 clears sr_flags[i]; likewise ovr_wdata[i] = 0 clears ovr_flags[i]. Writing 1 leaves the bit unchanged.
- Simultaneous set (hw or sw) and clear on the same bit in the same cycle: set wins and the flag ends at 1. The overcapture check uses the pre-edge flag value, and a same-cycle clear suppresses ovr.
- dier: loaded from dier_wdata on dier_we, otherwise holds.
- irq: combinational OR of (sr_flags & dier) from registered state. It therefore rises the cycle after the flag-setting edge and falls the cycle after the clearing edge.
- Priority within a cycle: rst > set > clear > hold.
- N_EVT = 1: only UG/UIF exist and ovr_flags = 0.

Test Plan:
- Reset then egr_we = 1, egr_wdata = 4'b0001, urs = 0 -> evt_pulse = 4'b0001 for exactly one cycle; sr_flags = 4'b0001 from the same edge; egr_rdata stays 0.
- Same write with urs = 1 -> evt_pulse[0] pulses, sr_flags stays 0; then hw_evt[0] = 1 -> sr_flags[0] = 1 regardless of urs.
- dier = 4'b0100, hw_evt = 4'b0100 -> sr_flags[2] = 1 and irq = 1 next cycle; sr_we = 1 with sr_wdata = 4'b1011 -> flag 2 clears, irq drops; bits 0/1/3 unchanged.
- hw_evt[1] twice, 3 cycles apart, with no clear -> ovr_flags = 4'b0010 after the second; sr_we = 1 with ovr_wdata = 4'b1101 -> ovr_flags = 0.
- Same cycle: hw_evt[3] = 1 and sr_we = 1 with sr_wdata[3] = 0, flag previously 1 -> sr_flags[3] = 1 and ovr_flags[3] = 0.
- egr_we with egr_wdata = 4'b1111 and rst asserted asynchronously mid-cycle -> evt_pulse = 0 immediately, all flags 0, and no pulse after rst deasserts.
